// File: rtl/asl_pkg.sv
// Shared types and constants for the bin readout controller.
// Geometry of the binned image, pixel and sum widths, FSM encoding and a
// few small helpers used by the controller and the per-channel scaler.
package asl_pkg;

  localparam int BIN_COLS  = 32;
  localparam int BIN_ROWS  = 32;
  localparam int BIN_SUM_W = 16;
  localparam int PIX_W     = 8;

  localparam int COL_W     = 5;
  localparam int ROW_W     = 5;
  localparam int BIN_ROW_W = 6;
  localparam int PROD_W    = 20;

  localparam logic [COL_W-1:0] LAST_COL = 5'd31;
  localparam logic [ROW_W-1:0] LAST_ROW = 5'd31;
  localparam logic [PIX_W-1:0] PIX_MAX  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    WAIT_ROW = 3'd2,
    STREAM   = 3'd3,
    FINISH   = 3'd4,
    RELEASE  = 3'd5
  } state_t;

  // The binner reports completed rows 1..32; the row just finished is one less.
  function automatic logic [ROW_W-1:0] readout_row(input logic [BIN_ROW_W-1:0] bin_row);
    logic [BIN_ROW_W-1:0] r;
    r = bin_row - 6'd1;
    return r[ROW_W-1:0];
  endfunction

  // Final pixel of the frame.
  function automatic logic is_last_pixel(input logic [ROW_W-1:0] row,
                                         input logic [COL_W-1:0] col);
    return (row == LAST_ROW) && (col == LAST_COL);
  endfunction

  // Output word layout is {R, G, B}.
  function automatic logic [3*PIX_W-1:0] pack_rgb(input logic [PIX_W-1:0] r,
                                                  input logic [PIX_W-1:0] g,
                                                  input logic [PIX_W-1:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/bin_scale.sv
// One colour channel of the readout path: bin sum times SCALE_MUL in a
// 20-bit product, right shift by SCALE_SHIFT, then clamp to 8 bits.
// Purely combinational; the controller registers the result.
module bin_scale
  import asl_pkg::*;
#(
  parameter int SCALE_MUL   = 75,
  parameter int SCALE_SHIFT = 11
) (
  input  logic [BIN_SUM_W-1:0] sum_i,
  output logic [PIX_W-1:0]     pix_o
);

  logic [PROD_W-1:0] prod_s;
  logic [PROD_W-1:0] shifted_s;

  // Multiply, shift and saturate one channel.
  always_comb begin
    prod_s    = 20'(sum_i) * 20'(SCALE_MUL);
    shifted_s = prod_s >> SCALE_SHIFT;
    if (shifted_s > 20'(PIX_MAX)) begin
      pix_o = PIX_MAX;
    end else begin
      pix_o = shifted_s[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/bin_readout_ctrl.sv
// Frame readout controller for the pixel binner.
// Starts the binner on request, watches its completed-row counter and
// streams each finished row (32 pixels, scaled to 8-bit RGB) over a
// valid/ready interface. The binner double-buffers rows in two banks; the
// bank just completed is the one opposite the LSB of the new row count.
// A new row arriving while the previous one is still streaming is an
// overrun: the old row is dropped and streaming restarts on the new row.
module bin_readout_ctrl
  import asl_pkg::*;
#(
  parameter int SCALE_MUL   = 75,
  parameter int SCALE_SHIFT = 11
) (
  input  logic                                    clk,
  input  logic                                    resetn,
  input  logic                                    frame_req,
  output logic                                    start_en,
  input  logic                                    bin_idle,
  input  logic [5:0]                              bin_row,
  input  logic [1:0][BIN_COLS-1:0][BIN_SUM_W-1:0] bin_r,
  input  logic [1:0][BIN_COLS-1:0][BIN_SUM_W-1:0] bin_g,
  input  logic [1:0][BIN_COLS-1:0][BIN_SUM_W-1:0] bin_b,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [23:0]                             out_data,
  output logic [4:0]                              out_row,
  output logic [4:0]                              out_col,
  output logic                                    out_last,
  output logic                                    frame_done,
  output logic                                    overrun
);

  state_t               state_q, state_d;
  logic [BIN_ROW_W-1:0] bin_row_q;
  logic                 start_en_q, start_en_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_done_q, frame_done_d;
  logic                 bank_q, bank_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [COL_W-1:0]     fetch_col_q, fetch_col_d;
  logic                 fetch_done_q, fetch_done_d;
  logic                 out_valid_q, out_valid_d;
  logic [3*PIX_W-1:0]   out_data_q, out_data_d;
  logic [ROW_W-1:0]     out_row_q, out_row_d;
  logic [COL_W-1:0]     out_col_q, out_col_d;
  logic                 out_last_q, out_last_d;

  logic                 row_evt_s;
  logic                 xfer_s;
  logic                 last_xfer_s;
  logic                 slot_free_s;
  logic [BIN_SUM_W-1:0] sum_r_s, sum_g_s, sum_b_s;
  logic [PIX_W-1:0]     pix_r_s, pix_g_s, pix_b_s;

  // Handshake and row-event decode; a counter reset to 0 is not a new row.
  always_comb begin
    row_evt_s   = (bin_row != bin_row_q) && (bin_row != 6'd0);
    xfer_s      = out_valid_q & out_ready;
    last_xfer_s = xfer_s && (out_col_q == LAST_COL);
    slot_free_s = ~out_valid_q | out_ready;
  end

  // Select the sums for the column being fetched from the completed bank.
  always_comb begin
    sum_r_s = bin_r[bank_q][fetch_col_q];
    sum_g_s = bin_g[bank_q][fetch_col_q];
    sum_b_s = bin_b[bank_q][fetch_col_q];
  end

  bin_scale #(.SCALE_MUL(SCALE_MUL), .SCALE_SHIFT(SCALE_SHIFT)) u_scale_r (
    .sum_i (sum_r_s),
    .pix_o (pix_r_s)
  );

  bin_scale #(.SCALE_MUL(SCALE_MUL), .SCALE_SHIFT(SCALE_SHIFT)) u_scale_g (
    .sum_i (sum_g_s),
    .pix_o (pix_g_s)
  );

  bin_scale #(.SCALE_MUL(SCALE_MUL), .SCALE_SHIFT(SCALE_SHIFT)) u_scale_b (
    .sum_i (sum_b_s),
    .pix_o (pix_b_s)
  );

  // Next-state, fetch pointer and output-slot logic.
  always_comb begin
    state_d      = state_q;
    start_en_d   = start_en_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    bank_d       = bank_q;
    row_d        = row_q;
    fetch_col_d  = fetch_col_q;
    fetch_done_d = fetch_done_q;
    out_valid_d  = out_valid_q & ~xfer_s;
    out_data_d   = out_data_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    out_last_d   = out_last_q;

    case (state_q)
      IDLE: begin
        if (frame_req && bin_idle) begin
          state_d    = ARM;
          start_en_d = 1'b1;
          overrun_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      ARM: begin
        if (!bin_idle) begin
          state_d = WAIT_ROW;
        end else begin
          state_d = ARM;
        end
      end

      WAIT_ROW: begin
        if (row_evt_s) begin
          state_d      = STREAM;
          bank_d       = ~bin_row[0];
          row_d        = readout_row(bin_row);
          fetch_col_d  = 5'd0;
          fetch_done_d = 1'b0;
        end else begin
          state_d = WAIT_ROW;
        end
      end

      STREAM: begin
        if (row_evt_s) begin
          // New row landed before this one drained: drop the rest and restart.
          if (!last_xfer_s) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
          state_d      = STREAM;
          bank_d       = ~bin_row[0];
          row_d        = readout_row(bin_row);
          fetch_col_d  = 5'd0;
          fetch_done_d = 1'b0;
          out_valid_d  = 1'b0;
        end else begin
          if (slot_free_s && !fetch_done_q) begin
            out_valid_d = 1'b1;
            out_data_d  = pack_rgb(pix_r_s, pix_g_s, pix_b_s);
            out_row_d   = row_q;
            out_col_d   = fetch_col_q;
            out_last_d  = is_last_pixel(row_q, fetch_col_q);
            if (fetch_col_q == LAST_COL) begin
              fetch_done_d = 1'b1;
            end else begin
              fetch_col_d = fetch_col_q + 5'd1;
            end
          end else begin
            out_valid_d = out_valid_q & ~xfer_s;
          end
          if (last_xfer_s) begin
            state_d = (row_q == LAST_ROW) ? FINISH : WAIT_ROW;
          end else begin
            state_d = STREAM;
          end
        end
      end

      FINISH: begin
        start_en_d = 1'b0;
        state_d    = RELEASE;
      end

      RELEASE: begin
        if (bin_idle) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end

      default: begin
        state_d    = IDLE;
        start_en_d = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, bin_row sampling and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      bin_row_q    <= 6'd0;
      start_en_q   <= 1'b0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
      bank_q       <= 1'b0;
      row_q        <= 5'd0;
      fetch_col_q  <= 5'd0;
      fetch_done_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 24'd0;
      out_row_q    <= 5'd0;
      out_col_q    <= 5'd0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_row_q    <= bin_row;
      start_en_q   <= start_en_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
      bank_q       <= bank_d;
      row_q        <= row_d;
      fetch_col_q  <= fetch_col_d;
      fetch_done_q <= fetch_done_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      out_last_q   <= out_last_d;
    end
  end

  assign start_en   = start_en_q;
  assign overrun    = overrun_q;
  assign frame_done = frame_done_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_bin_readout_ctrl.sv
// Bench for bin_readout_ctrl: a behavioural binner drives rows into the two
// banks and pushes the expected pixels to a scoreboard; a monitor pops and
// compares every transfer and checks that stalled outputs hold steady.
module tb_bin_readout_ctrl;
  import asl_pkg::*;

  typedef struct packed {
    logic [23:0] data;
    logic [4:0]  row;
    logic [4:0]  col;
    logic        last;
  } pix_t;

  logic clk = 1'b0;
  logic resetn, frame_req, start_en, bin_idle;
  logic [5:0] bin_row;
  logic [1:0][31:0][15:0] bin_r, bin_g, bin_b;
  logic out_valid, out_ready, out_last, frame_done, overrun;
  logic [23:0] out_data;
  logic [4:0] out_row, out_col;

  pix_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   xfer_cnt = 0;
  int   rdy_mode = 0;
  bit   chk_stable = 1'b1;

  bin_readout_ctrl #(.SCALE_MUL(75), .SCALE_SHIFT(11)) dut (
    .clk(clk), .resetn(resetn), .frame_req(frame_req), .start_en(start_en),
    .bin_idle(bin_idle), .bin_row(bin_row), .bin_r(bin_r), .bin_g(bin_g), .bin_b(bin_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference scaling: integer arithmetic, product kept to 20 bits.
  function automatic logic [7:0] ref_scale(input int s);
    int p;
    p = ((s * 75) % 1048576) / 2048;
    if (p > 255) p = 255;
    return 8'(p);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Downstream ready generator: 0 = stall, 1 = always ready, 2 = random.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Transfer monitor: scoreboard compare and hold-while-stalled check.
  initial begin
    bit   prev_stall;
    pix_t prev_pix, obs, exp;
    prev_stall = 1'b0;
    prev_pix   = '0;
    forever begin
      @(negedge clk);
      obs.data = out_data; obs.row = out_row; obs.col = out_col; obs.last = out_last;
      if (resetn) begin
        if (chk_stable && prev_stall) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_pixel", 64'(obs), 64'(prev_pix));
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL extra_pixel: observed pixel 0x%0h, expected none", obs);
          end else begin
            exp = sb_q.pop_front();
            check("pixel", 64'(obs), 64'(exp));
          end
          xfer_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_pix   = obs;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // One frame as seen from the binner side.
  task automatic run_frame(input bit rand_rdy, input int ovr_row, input int rst_row,
                           input bit req_in_wait, output bit aborted);
    logic [15:0] tsum [4];
    logic [7:0]  tpix [4];
    int          base;
    pix_t        p;
    tsum = '{16'd0, 16'd225, 16'd3000, 16'd6975};
    tpix = '{8'd0, 8'd8, 8'd109, 8'd255};
    aborted  = 1'b0;
    base     = xfer_cnt;
    rdy_mode = rand_rdy ? 2 : 1;

    frame_req = 1'b1;
    cyc(1);
    frame_req = 1'b0;
    check("start_en_set", 64'(start_en), 64'd1);
    check("overrun_clear", 64'(overrun), 64'd0);
    cyc(1);
    bin_idle = 1'b0;
    cyc(2);
    bin_row = 6'd0;
    cyc(3);
    check("row0_ignored", 64'(out_valid), 64'd0);

    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        int sr, sg, sb;
        if (r == 0 && c < 4) begin
          sr = int'(tsum[c]); sg = int'(tsum[(c + 1) % 4]); sb = int'(tsum[(c + 2) % 4]);
          p.data = {tpix[c], tpix[(c + 1) % 4], tpix[(c + 2) % 4]};
        end else begin
          sr = int'($urandom_range(0, 13000));
          sg = int'($urandom_range(0, 13000));
          sb = int'($urandom_range(0, 13000));
          p.data = {ref_scale(sr), ref_scale(sg), ref_scale(sb)};
        end
        bin_r[r % 2][c] = 16'(sr);
        bin_g[r % 2][c] = 16'(sg);
        bin_b[r % 2][c] = 16'(sb);
        p.row  = 5'(r);
        p.col  = 5'(c);
        p.last = (r == 31) && (c == 31);
        sb_q.push_back(p);
      end

      if (r == ovr_row) begin
        // Stall mid-row, then let the next row land on top of it.
        for (int i = 0; i < 2000 && sb_q.size() > 52; i++) cyc(1);
        check("ovr_reach", 64'(sb_q.size() <= 52), 64'd1);
        rdy_mode = 0;
        cyc(3);
        while (sb_q.size() > 32) void'(sb_q.pop_front());
        base = xfer_cnt;
        chk_stable = 1'b0;
        bin_row = 6'(r + 1);
        cyc(3);
        check("ovr_flag", 64'(overrun), 64'd1);
        check("ovr_valid", 64'(out_valid), 64'd1);
        check("ovr_restart", 64'({out_row, out_col}), 64'({5'(r), 5'd0}));
        check("ovr_no_xfer", 64'(xfer_cnt), 64'(base));
        chk_stable = 1'b1;
        rdy_mode = rand_rdy ? 2 : 1;
      end else begin
        for (int i = 0; i < 2000 && sb_q.size() > 32; i++) cyc(1);
        check("row_drain", 64'(sb_q.size() <= 32), 64'd1);
        if (req_in_wait && r == 3) begin
          frame_req = 1'b1;
          cyc(1);
          frame_req = 1'b0;
          check("req_ignored_en", 64'(start_en), 64'd1);
          check("req_ignored_vld", 64'(out_valid), 64'd0);
        end
        cyc(2);
        bin_row = 6'(r + 1);
        if (r == 0 && !rand_rdy) begin
          @(negedge clk);
          @(negedge clk);
          check("lat_c1", 64'(out_valid), 64'd0);
          @(negedge clk);
          check("lat_c2", 64'(out_valid), 64'd1);
          @(posedge clk);
          #1;
        end
      end

      if (r == rst_row) begin
        cyc(5);
        resetn = 1'b0;
        #1;
        check("rst_async", 64'({start_en, out_valid, out_data, out_row, out_col,
                                out_last, frame_done, overrun}), 64'd0);
        @(posedge clk);
        #1;
        check("rst_edge", 64'({start_en, out_valid, out_data, out_row, out_col,
                               out_last, frame_done, overrun}), 64'd0);
        sb_q.delete();
        bin_idle = 1'b1;
        bin_row  = 6'd0;
        cyc(3);
        resetn = 1'b1;
        cyc(2);
        aborted = 1'b1;
        return;
      end
    end

    for (int i = 0; i < 4000 && sb_q.size() > 0; i++) cyc(1);
    check("frame_drained", 64'(sb_q.size()), 64'd0);
    if (ovr_row < 0) check("xfer_count", 64'(xfer_cnt - base), 64'd1024);
    for (int i = 0; i < 100 && start_en; i++) cyc(1);
    check("start_en_drop", 64'(start_en), 64'd0);
    cyc(3);
    bin_idle = 1'b1;
    @(negedge clk);
    check("done_early", 64'(frame_done), 64'd0);
    @(negedge clk);
    check("done_pulse", 64'(frame_done), 64'd1);
    @(negedge clk);
    check("done_single", 64'(frame_done), 64'd0);
    @(posedge clk);
    #1;
    if (req_in_wait) begin
      cyc(10);
      check("no_second_frame", 64'({start_en, out_valid}), 64'd0);
    end
  endtask

  // Watchdog so a stuck handshake still ends the run.
  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence.
  initial begin
    bit ab;
    resetn    = 1'b0;
    frame_req = 1'b0;
    bin_idle  = 1'b1;
    bin_row   = 6'd0;
    bin_r = '0; bin_g = '0; bin_b = '0;
    cyc(2);
    check("reset_outs", 64'({start_en, out_valid, out_data, out_row, out_col,
                             out_last, frame_done, overrun}), 64'd0);
    resetn = 1'b1;
    cyc(2);

    run_frame(1'b0, -1, -1, 1'b1, ab);
    run_frame(1'b1, -1, -1, 1'b0, ab);
    run_frame(1'b0,  5, -1, 1'b0, ab);
    check("overrun_sticky", 64'(overrun), 64'd1);
    run_frame(1'b0, -1, 10, 1'b0, ab);
    check("reset_aborted", 64'(ab), 64'd1);
    run_frame(1'b0, -1, -1, 1'b0, ab);
    check("post_reset_ovr", 64'(overrun), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
